clk_divide_multi: RTL and testbench

//  Multi-channel, runtime-programmable integer clock divider; successor to the fixed power-of-two divider.

---
 rtl/clk_divide_multi_if.sv | 38 +++
 rtl/clk_divide_multi.sv | 88 ++++++++
 tb/tb_clk_divide_multi.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_divide_multi_if.sv
// Control and output bundle for clk_divide_multi: run enables, divisor write port and divided outputs.
// i_sync is present only when CLK_DIV_SYNC_EN is defined.
interface clk_divide_multi_if #(
  parameter int NUM_CH    = 4,
  parameter int DIV_WIDTH = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]    i_en;
  logic                 i_wr_en;
  logic [CH_W-1:0]      i_wr_ch;
  logic [DIV_WIDTH-1:0] i_wr_div;
`ifdef CLK_DIV_SYNC_EN
  logic                 i_sync;
`endif
  logic [NUM_CH-1:0]    o_clk_out;
  logic [NUM_CH-1:0]    o_tick;

`ifdef CLK_DIV_SYNC_EN
  modport master (
    output i_en, i_wr_en, i_wr_ch, i_wr_div, i_sync,
    input  o_clk_out, o_tick
  );
  modport slave (
    input  i_en, i_wr_en, i_wr_ch, i_wr_div, i_sync,
    output o_clk_out, o_tick
  );
`else
  modport master (
    output i_en, i_wr_en, i_wr_ch, i_wr_div,
    input  o_clk_out, o_tick
  );
  modport slave (
    input  i_en, i_wr_en, i_wr_ch, i_wr_div,
    output o_clk_out, o_tick
  );
`endif
endinterface

// File: rtl/clk_divide_multi.sv
// NUM_CH runtime-programmable integer clock dividers with registered near-50% clocks and period ticks.
// Outputs are one edge after inputs; no backpressure. CLK_DIV_SYNC_EN adds a phase-align input.
module clk_divide_multi #(
  parameter int NUM_CH      = 4,
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  clk_divide_multi_if.slave    io_bus
);
  localparam int                   CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_TWO = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DEFAULT_DIV);

  logic [DIV_WIDTH-1:0] r_shadow [NUM_CH];
  logic [DIV_WIDTH-1:0] r_active [NUM_CH];
  logic [DIV_WIDTH-1:0] r_cnt    [NUM_CH];
  logic [NUM_CH-1:0]    r_run;
  logic [NUM_CH-1:0]    r_clk_out;
  logic [NUM_CH-1:0]    r_tick;

  logic [DIV_WIDTH-1:0] w_shadow_fwd [NUM_CH];
  logic [DIV_WIDTH-1:0] w_act_nxt    [NUM_CH];
  logic [DIV_WIDTH-1:0] w_cnt_nxt    [NUM_CH];
  logic [NUM_CH-1:0]    w_run_nxt;
  logic [NUM_CH-1:0]    w_clk_nxt;
  logic [NUM_CH-1:0]    w_tick_nxt;
  logic                 w_sync;

`ifdef CLK_DIV_SYNC_EN
  assign w_sync = io_bus.i_sync;
`else
  assign w_sync = 1'b0;
`endif

  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      // A write in the same cycle as a reload lands in the new period immediately.
      w_shadow_fwd[ch] = (io_bus.i_wr_en && (io_bus.i_wr_ch == CH_W'(ch))) ?
                         io_bus.i_wr_div : r_shadow[ch];
      w_cnt_nxt[ch]    = '0;
      w_act_nxt[ch]    = w_shadow_fwd[ch];
      w_run_nxt[ch]    = 1'b0;

      if (io_bus.i_en[ch] && (r_active[ch] >= DIV_TWO)) begin
        w_run_nxt[ch] = 1'b1;
        if (w_sync || !r_run[ch] || (r_cnt[ch] == (r_active[ch] - DIV_ONE))) begin
          w_cnt_nxt[ch] = '0;
          w_act_nxt[ch] = w_shadow_fwd[ch];
        end else begin
          w_cnt_nxt[ch] = r_cnt[ch] + DIV_ONE;
          w_act_nxt[ch] = r_active[ch];
        end
      end

      // A reload to D<2 yields a low output and no tick; the channel idles next edge.
      w_clk_nxt[ch]  = w_run_nxt[ch] && (w_cnt_nxt[ch] < (w_act_nxt[ch] >> 1));
      w_tick_nxt[ch] = w_run_nxt[ch] && (w_cnt_nxt[ch] == '0) && (w_act_nxt[ch] >= DIV_TWO);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_shadow[ch] <= DIV_RST;
        r_active[ch] <= DIV_RST;
        r_cnt[ch]    <= '0;
      end
      r_run     <= '0;
      r_clk_out <= '0;
      r_tick    <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        r_shadow[ch] <= w_shadow_fwd[ch];
        r_active[ch] <= w_act_nxt[ch];
        r_cnt[ch]    <= w_cnt_nxt[ch];
      end
      r_run     <= w_run_nxt;
      r_clk_out <= w_clk_nxt;
      r_tick    <= w_tick_nxt;
    end
  end

  assign io_bus.o_clk_out = r_clk_out;
  assign io_bus.o_tick    = r_tick;
endmodule

// File: tb/tb_clk_divide_multi.sv
// Directed bench for clk_divide_multi: reset, divisor values, period-boundary reloads, enable and reset overrides.
// The phase-alignment scenario is included when CLK_DIV_SYNC_EN is defined.
module tb_clk_divide_multi;
  localparam int NUM_CH    = 4;
  localparam int DIV_WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  clk_divide_multi_if #(.NUM_CH(NUM_CH), .DIV_WIDTH(DIV_WIDTH)) bus ();

  clk_divide_multi #(
    .NUM_CH(NUM_CH),
    .DIV_WIDTH(DIV_WIDTH),
    .DEFAULT_DIV(8)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_div(input int ch, input int d);
    bus.i_wr_en  = 1'b1;
    bus.i_wr_ch  = 2'(ch);
    bus.i_wr_div = 8'(d);
    step();
    bus.i_wr_en  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_en = 4'b1111;
    step();
    step();
    n_tests++;
    if (bus.o_clk_out !== 4'b0000 || bus.o_tick !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs clk=%b tick=%b want 0000/0000", bus.o_clk_out, bus.o_tick);
    end
    bus.i_en = 4'b0000;
    rst = 1'b0;
    step();
    n_tests++;
    if (bus.o_clk_out !== 4'b0000 || bus.o_tick !== 4'b0000) begin
      n_fail++;
      $display("FAIL disabled_outputs clk=%b tick=%b want 0000/0000", bus.o_clk_out, bus.o_tick);
    end
  endtask

  task automatic test_default_div();
    logic exp_clk, exp_tick;
    bus.i_en = 4'b0001;
    for (int k = 0; k < 16; k++) begin
      step();
      exp_clk  = ((k % 8) < 4);
      exp_tick = ((k % 8) == 0);
      n_tests++;
      if (bus.o_clk_out[0] !== exp_clk || bus.o_tick[0] !== exp_tick) begin
        n_fail++;
        $display("FAIL default_div k=%0d clk=%b tick=%b want %b/%b",
                 k, bus.o_clk_out[0], bus.o_tick[0], exp_clk, exp_tick);
      end
      n_tests++;
      if (bus.o_clk_out[3:1] !== 3'b000 || bus.o_tick[3:1] !== 3'b000) begin
        n_fail++;
        $display("FAIL other_channels_idle k=%0d clk=%b tick=%b want 000/000",
                 k, bus.o_clk_out[3:1], bus.o_tick[3:1]);
      end
    end
    bus.i_en = 4'b0000;
    step();
  endtask

  task automatic test_div_values();
    int divs[4] = '{5, 2, 1, 0};
    logic exp_clk, exp_tick;
    foreach (divs[i]) begin
      bus.i_en = 4'b0000;
      write_div(1, divs[i]);
      bus.i_en = 4'b0010;
      for (int k = 0; k < 10; k++) begin
        step();
        if (divs[i] >= 2) begin
          exp_clk  = ((k % divs[i]) < (divs[i] / 2));
          exp_tick = ((k % divs[i]) == 0);
        end else begin
          exp_clk  = 1'b0;
          exp_tick = 1'b0;
        end
        n_tests++;
        if (bus.o_clk_out[1] !== exp_clk || bus.o_tick[1] !== exp_tick) begin
          n_fail++;
          $display("FAIL div_%0d k=%0d clk=%b tick=%b want %b/%b",
                   divs[i], k, bus.o_clk_out[1], bus.o_tick[1], exp_clk, exp_tick);
        end
      end
    end
    bus.i_en = 4'b0000;
    step();
  endtask

  task automatic test_reload_boundary();
    logic exp_clk, exp_tick;
    // Pass 0 writes D=4 while cnt=2, pass 1 writes it in the wrap cycle (cnt=7).
    for (int pass = 0; pass < 2; pass++) begin
      bus.i_en = 4'b0000;
      write_div(0, 8);
      bus.i_en = 4'b0001;
      for (int k = 0; k < 16; k++) begin
        if ((pass == 0 && k == 3) || (pass == 1 && k == 8)) begin
          bus.i_wr_en  = 1'b1;
          bus.i_wr_ch  = 2'd0;
          bus.i_wr_div = 8'd4;
        end
        step();
        bus.i_wr_en = 1'b0;
        if (k < 8) begin
          exp_clk  = ((k % 8) < 4);
          exp_tick = (k == 0);
        end else begin
          exp_clk  = (((k - 8) % 4) < 2);
          exp_tick = (((k - 8) % 4) == 0);
        end
        n_tests++;
        if (bus.o_clk_out[0] !== exp_clk || bus.o_tick[0] !== exp_tick) begin
          n_fail++;
          $display("FAIL reload_pass%0d k=%0d clk=%b tick=%b want %b/%b",
                   pass, k, bus.o_clk_out[0], bus.o_tick[0], exp_clk, exp_tick);
        end
      end
    end
    bus.i_en = 4'b0000;
    step();
  endtask

  task automatic test_en_drop();
    logic exp_clk, exp_tick;
    bus.i_en = 4'b0100;
    step();
    step();
    n_tests++;
    if (bus.o_clk_out[2] !== 1'b1 || bus.o_tick[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL en_drop_pre clk=%b tick=%b want 1/0", bus.o_clk_out[2], bus.o_tick[2]);
    end
    bus.i_en = 4'b0000;
    step();
    n_tests++;
    if (bus.o_clk_out[2] !== 1'b0 || bus.o_tick[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL en_drop_low clk=%b tick=%b want 0/0", bus.o_clk_out[2], bus.o_tick[2]);
    end
    bus.i_en = 4'b0100;
    for (int k = 0; k < 9; k++) begin
      step();
      exp_clk  = ((k % 8) < 4);
      exp_tick = ((k % 8) == 0);
      n_tests++;
      if (bus.o_clk_out[2] !== exp_clk || bus.o_tick[2] !== exp_tick) begin
        n_fail++;
        $display("FAIL en_reraise k=%0d clk=%b tick=%b want %b/%b",
                 k, bus.o_clk_out[2], bus.o_tick[2], exp_clk, exp_tick);
      end
    end
    bus.i_en = 4'b0000;
    step();
  endtask

  task automatic test_rst_override();
    logic [3:0] exp_clk, exp_tick;
    bus.i_en = 4'b0000;
    write_div(0, 3);
    write_div(1, 5);
    write_div(2, 6);
    write_div(3, 2);
    bus.i_en = 4'b1111;
    step();
    step();
    step();
    rst          = 1'b1;
    bus.i_wr_en  = 1'b1;
    bus.i_wr_ch  = 2'd0;
    bus.i_wr_div = 8'd2;
    step();
    n_tests++;
    if (bus.o_clk_out !== 4'b0000 || bus.o_tick !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_override clk=%b tick=%b want 0000/0000", bus.o_clk_out, bus.o_tick);
    end
    rst         = 1'b0;
    bus.i_wr_en = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      exp_clk  = ((k % 8) < 4) ? 4'b1111 : 4'b0000;
      exp_tick = ((k % 8) == 0) ? 4'b1111 : 4'b0000;
      n_tests++;
      if (bus.o_clk_out !== exp_clk || bus.o_tick !== exp_tick) begin
        n_fail++;
        $display("FAIL rst_default_restored k=%0d clk=%b tick=%b want %b/%b",
                 k, bus.o_clk_out, bus.o_tick, exp_clk, exp_tick);
      end
    end
    bus.i_en = 4'b0000;
    step();
  endtask

`ifdef CLK_DIV_SYNC_EN
  task automatic test_sync();
    logic [1:0] exp_clk, exp_tick;
    bus.i_en = 4'b0000;
    write_div(0, 6);
    write_div(1, 3);
    bus.i_en = 4'b0001;
    step();
    step();
    bus.i_en = 4'b0011;
    step();
    step();
    bus.i_sync = 1'b1;
    step();
    bus.i_sync = 1'b0;
    n_tests++;
    if (bus.o_clk_out[1:0] !== 2'b11 || bus.o_tick[1:0] !== 2'b11) begin
      n_fail++;
      $display("FAIL sync_align clk=%b tick=%b want 11/11", bus.o_clk_out[1:0], bus.o_tick[1:0]);
    end
    for (int k = 1; k < 13; k++) begin
      step();
      exp_clk  = {((k % 3) < 1), ((k % 6) < 3)};
      exp_tick = {((k % 3) == 0), ((k % 6) == 0)};
      n_tests++;
      if (bus.o_clk_out[1:0] !== exp_clk || bus.o_tick[1:0] !== exp_tick) begin
        n_fail++;
        $display("FAIL sync_after k=%0d clk=%b tick=%b want %b/%b",
                 k, bus.o_clk_out[1:0], bus.o_tick[1:0], exp_clk, exp_tick);
      end
    end
    bus.i_en = 4'b0000;
    step();
  endtask
`endif

  initial begin
    rst          = 1'b1;
    bus.i_en     = 4'b0000;
    bus.i_wr_en  = 1'b0;
    bus.i_wr_ch  = 2'd0;
    bus.i_wr_div = 8'd0;
`ifdef CLK_DIV_SYNC_EN
    bus.i_sync   = 1'b0;
`endif
    test_reset();
    test_default_div();
    test_div_values();
    test_reload_boundary();
    test_en_drop();
    test_rst_override();
`ifdef CLK_DIV_SYNC_EN
    test_sync();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
